instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Counterpart of the CPU control/decode path: takes decoded RISC-V RV32I instruction fields and assembles each into a 32-bit instruction word.
- Writes each word into instruction memory through its write port at consecutive word addresses.
- Used by testbenches and the boot/program-load path to build programs from field tuples instead of hex files.
- Sequential core: load state machine, valid/ready input handshake, address counter, registered write stage, sticky error flags.

Parameters:
ADDRESS_WIDTH, 32, width of instruction-memory byte address.
DEPTH_WORDS, 1024, maximum words written per load session.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE).
base_addr  input  ADDRESS_WIDTH  first byte address of the session, sampled on start.
in_valid  input  1  field tuple valid.
in_ready  output  1  encoder accepts tuple this cycle.
in_last  input  1  tuple is the final one of the session.
fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
opcode  input  7  instruction opcode.
rd  input  5  destination register.
rs1  input  5  source register 1.
rs2  input  5  source register 2.
funct3  input  3  funct3 field.
funct7b5  input  1  instr[30] selector (sub/sra/srai).
imm  input  32  sign-extended immediate or byte offset.
wr_en  output  1  instruction-memory write strobe.
wr_addr  output  ADDRESS_WIDTH  write byte address.
wr_data  output  32  encoded instruction.
busy  output  1  state is not IDLE.
done  output  1  one-cycle session-complete pulse.
err_fmt  output  1  sticky: illegal fmt seen.
err_align  output  1  sticky: B/J imm[0]=1 seen.
err_ovf  output  1  sticky: DEPTH_WORDS reached without in_last.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, word count 0, address register 0. All outputs 0, including wr_addr and wr_data.
- States and transitions:
  - IDLE: on start, latch base_addr with bits [1:0] forced to 0, clear count and all error flags, go to LOAD.
  - LOAD: in_ready = 1 while count < DEPTH_WORDS. A transfer occurs when in_valid and in_ready are both 1.
  - LOAD -> DONE: after a transfer with in_last=1, or when count reaches DEPTH_WORDS (in the latter case set err_ovf).
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE.
- Latency: a transfer in cycle N drives wr_en=1, wr_addr and wr_data in cycle N+1 (registered). With in_valid held high, throughput is one word per cycle.
- done coincides with wr_en of the final word.
- Address: wr_addr = base + 4*count. count increments only on a written word.
  - Address arithmetic wraps modulo 2^ADDRESS_WIDTH without error.
- Encoding (standard RV32I bit placement):
  - R: {0, funct7b5, 00000, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. When opcode=0010011 and funct3 is 001 or 101, bits [31:25] = {0, funct7b5, 00000} and bits [24:20] = imm[4:0].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Illegal fmt, or B/J with imm[0]=1:
  - The tuple is still accepted (handshake completes, in_last still honoured).
  - No write occurs and count does not advance.
  - The matching sticky flag sets; flags are cleared only by the next start or by reset.
- Unused fields for a format are ignored.
- The block does not validate opcode or funct3 against the format.
- rst_n asserted mid-session: immediate return to reset values; a pending write is lost.

Decomposition:
- Shared package (riscv_pkg): fmt enum, opcode constants, encoder state enum.
  - Opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_S=0100011, OP_B=1100011, OP_JAL=1101111, OP_JALR=1100111, OP_LUI=0110111, OP_AUIPC=0010111.
- One combinational sub-module, instr_pack: takes fields and produces the 32-bit word plus the illegal and misaligned flags.
- The top level holds the FSM, counter and output register.

Test Plan:
- start with base_addr=0x100, then addi x1,x0,5 (fmt I, in_last=1) -> one cycle later wr_en=1, wr_addr=0x100, wr_data=0x00500093, done=1; busy=0 the following cycle.
- Four back-to-back tuples: srai x6,x7,3; sw x2,4(x3); beq x0,x0,+8; jal x1,+16 -> wr_data 0x4033D313, 0x0021A223, 0x00000463, 0x010000EF at addresses base, +4, +8, +12 on consecutive cycles.
- lui x5 with imm=0x12345000, fmt U -> 0x123452B7. Then a B tuple with imm=7 -> no write, err_align=1, next word lands at the next unused address.
- fmt=6 tuple carrying in_last -> no write, err_fmt=1, done pulses; next start clears err_fmt.
- DEPTH_WORDS=4, six tuples offered without in_last -> exactly four writes, in_ready drops, err_ovf=1, done pulses.
- rst_n pulled low while wr_en=1 mid-session -> all outputs 0 immediately; start ignored while LOAD; start accepted after reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types: instruction formats, opcodes, encoder states
// and the decoded-field tuple consumed by the packer.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: one field tuple in, one instruction word
// out, plus flags for an illegal format and a misaligned branch/jump offset.
module instr_pack
  import riscv_pkg::*;
(
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          illegal,
  output logic          misalign
);

  logic is_shift_imm;
  assign is_shift_imm = (f.opcode == OP_I) && ((f.funct3 == 3'b001) || (f.funct3 == 3'b101));

  always_comb begin
    word     = '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (f.fmt)
      FMT_R: word = {1'b0, f.funct7b5, 5'b0, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: begin
        // shift-immediates carry shamt in [24:20] and the sra selector in bit 30
        if (is_shift_imm)
          word = {1'b0, f.funct7b5, 5'b0, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
        else
          word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      end
      FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_B: begin
        word     = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3, f.imm[4:1], f.imm[11], f.opcode};
        misalign = f.imm[0];
      end
      FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
      FMT_J: begin
        word     = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        misalign = f.imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: accepts field tuples over valid/ready, packs them and
// writes consecutive words into instruction memory through a registered port.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [2:0]               fmt,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic [31:0]              imm,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [31:0]              wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_fmt,
  output logic                     err_align,
  output logic                     err_ovf
);

  localparam int                CW      = $clog2(DEPTH_WORDS + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH_WORDS);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_STEP = ADDRESS_WIDTH'(4);

  enc_state_e               state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;
  logic                     err_fmt_q, err_fmt_d;
  logic                     err_align_q, err_align_d;
  logic                     err_ovf_q, err_ovf_d;

  instr_fields_t fields;
  logic [31:0]   word;
  logic          illegal, misalign, xfer;

  assign fields = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7b5: funct7b5, imm: imm};

  instr_pack u_pack (
    .f        (fields),
    .word     (word),
    .illegal  (illegal),
    .misalign (misalign)
  );

  assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_fmt_d   = err_fmt_q;
    err_align_d = err_align_q;
    err_ovf_d   = err_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr & ~ADDRESS_WIDTH'(3);
          count_d     = '0;
          err_fmt_d   = 1'b0;
          err_align_d = 1'b0;
          err_ovf_d   = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          // rejected tuples still complete the handshake but leave no hole
          if (illegal)       err_fmt_d   = 1'b1;
          else if (misalign) err_align_d = 1'b1;
          else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word;
            addr_d    = addr_q + WORD_STEP;
            count_d   = count_q + 1'b1;
          end
          if (in_last) state_d = ST_DONE;
          else if (count_d == DEPTH_C) begin
            state_d   = ST_DONE;
            err_ovf_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      addr_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_fmt_q   <= 1'b0;
      err_align_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_fmt_q   <= err_fmt_d;
      err_align_q <= err_align_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err_fmt   = err_fmt_q;
  assign err_align = err_align_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a
// negedge monitor pops and compares every write the DUT presents.
module tb_instr_encoder;

  logic        clk, rst_n, start, in_valid, in_ready, in_last;
  logic [31:0] base_addr, imm, wr_addr, wr_data;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic        funct7b5, wr_en, busy, done, err_fmt, err_align, err_ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  instr_encoder #(.ADDRESS_WIDTH(32), .DEPTH_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7b5(funct7b5), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_fmt(err_fmt), .err_align(err_align),
    .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", wr_addr, mon_e.addr);
        chk("wr_data", wr_data, mon_e.data);
        chk("done_with_write", {31'b0, done}, {31'b0, mon_e.done});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic f7, input logic [31:0] im, input logic last,
                      input logic push, input logic [31:0] ea, input logic [31:0] ed,
                      input logic edone, output int waited);
    exp_t e;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3;
    funct7b5 = f7; imm = im; in_last = last; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 20 cycles");
        break;
      end
    end
    if (push && waited <= 20) begin
      e.addr = ea; e.data = ed; e.done = edone;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    #2;
    chk("rst_outputs", {wr_en, busy, done, err_fmt, err_align, err_ovf, in_ready}, 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // single addi with last
    do_start(32'h100);
    chk("ready_in_load", {31'b0, in_ready}, 32'h1);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 1'b1, 32'h100, 32'h00500093, 1'b1, w);
    in_valid = 1'b0;
    wait_cyc(1);
    chk("busy_after_done", {30'b0, busy, done}, 32'h0);

    // four back-to-back, base with low bits set, count reaches depth with last
    do_start(32'h203);
    send(3'd1, 7'h13, 5'd6, 5'd7, 5'd0, 3'd5, 1'b1, 32'd3, 1'b0, 1'b1, 32'h200, 32'h4033D313, 1'b0, w);
    send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 1'b0, 32'd4, 1'b0, 1'b1, 32'h204, 32'h0021A223, 1'b0, w);
    chk("b2b_wait_sw", w, 32'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0, 1'b1, 32'h208, 32'h00000463, 1'b0, w);
    chk("b2b_wait_beq", w, 32'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16, 1'b1, 1'b1, 32'h20C, 32'h010000EF, 1'b1, w);
    chk("b2b_wait_jal", w, 32'd0);
    in_valid = 1'b0;
    wait_cyc(1);
    chk("no_ovf_on_last_at_depth", {31'b0, err_ovf}, 32'h0);

    // lui, misaligned branch (dropped), then next word at next unused address
    do_start(32'h1000);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0, 1'b1, 32'h1000, 32'h123452B7, 1'b0, w);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_align_set", {31'b0, err_align}, 32'h1);
    chk("no_write_misalign", {31'b0, wr_en}, 32'h0);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 1'b1, 32'h1004, 32'h00500093, 1'b1, w);
    in_valid = 1'b0;
    wait_cyc(1);
    chk("err_align_sticky", {30'b0, err_align, err_fmt}, 32'h2);

    // illegal fmt carrying last
    do_start(32'h40);
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("illegal_done_nowrite", {29'b0, done, wr_en, err_fmt}, 32'h5);
    wait_cyc(2);
    chk("err_fmt_sticky_idle", {30'b0, busy, err_fmt}, 32'h1);
    do_start(32'h80);
    chk("err_fmt_cleared", {31'b0, err_fmt}, 32'h0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1, 1'b1, 32'h80, 32'h00500093, 1'b1, w);
    in_valid = 1'b0;
    wait_cyc(1);

    // overflow: depth 4, no last, address wraps past 2^32
    do_start(32'hFFFFFFF8);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h00500093, 1'b0, w);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00500113, 1'b0, w);
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b1, 32'h00000000, 32'h00500193, 1'b0, w);
    send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b1, 32'h00000004, 32'h00500213, 1'b1, w);
    rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_ready_low", {31'b0, in_ready}, 32'h0);
    end
    chk("err_ovf_set", {31'b0, err_ovf}, 32'h1);
    in_valid = 1'b0;
    wait_cyc(1);

    // start ignored in LOAD, then reset while a write is presented
    do_start(32'h300);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b1, 32'h300, 32'h00500093, 1'b0, w);
    in_valid = 1'b0;
    wait_cyc(1);
    do_start(32'h500);
    chk("busy_in_load", {31'b0, busy}, 32'h1);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, 1'b1, 32'h304, 32'h402081B3, 1'b0, w);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, w);
    in_valid = 1'b0;
    chk("wr_en_before_rst", {31'b0, wr_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {wr_en, busy, done, err_fmt, err_align, err_ovf, in_ready}, 32'h0);
    chk("midrst_wr_addr", wr_addr, 32'h0);
    chk("midrst_wr_data", wr_data, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(32'h600);
    send(3'd2, 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 1'b0, 32'd4, 1'b1, 1'b1, 32'h600, 32'h0021A223, 1'b1, w);
    in_valid = 1'b0;
    wait_cyc(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
